counter_rco_monitor: RTL
========================

# counter_rco_monitor

Downstream consumer of the 4-bit `counter` block. It watches the counter's `rco`, `load` and `Q` outputs, counts wrap events, and measures the cycle distance between consecutive `rco` rising edges. Each measured period is checked against a programmed expected value. It sits between the counter and the scoreboard/checker logic, which reads its registered results and sticky error flags.

## Interface
Parameters:
- `PERIOD_W`, default 8: width of the period counter and period output.
- `WRAP_W`, default 8: width of the wrap-event counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rco`  in  1  ripple-carry-out from the counter.
- `load`  in  1  load indicator from the counter.
- `Q`  in  4  counter value.
- `exp_period`  in  PERIOD_W  expected cycles between `rco` rising edges; 0 disables checking.
- `clr_flags`  in  1  clears `mismatch` and `overflow`.
- `period`  out  PERIOD_W  last measured period.
- `period_valid`  out  1  one-cycle pulse when `period` updates.
- `q_snap`  out  4  `Q` sampled at the last accepted rco event.
- `wrap_count`  out  WRAP_W  number of accepted rco events, modulo 2^WRAP_W.
- `mismatch`  out  1  sticky: a measured period differed from a nonzero `exp_period`.
- `overflow`  out  1  sticky: the period counter saturated.
- `busy`  out  1  high in RUN state.

## Operation
- `rco_d` is a register holding the previous `rco`. An event is `rco & ~rco_d`, evaluated at a clock edge. A multi-cycle-high `rco` produces one event.
- The FSM has two states: IDLE and RUN.
- IDLE, on event (and `load`=0):
  - go to RUN
  - `cnt`<=1
  - `wrap_count`++
  - `q_snap`<=`Q`
  - no period is reported (this is the first edge).
- RUN, each cycle without event or load: `cnt`<=`cnt`+1, saturating at 2^PERIOD_W-1. Reaching saturation sets `overflow`.
- RUN, on event (and `load`=0):
  - `period`<=`cnt`
  - `period_valid`<=1
  - `wrap_count`++
  - `q_snap`<=`Q`
  - `cnt`<=1
  - `mismatch` is set if `exp_period`!=0 and `cnt`!=`exp_period`
  - stay in RUN.
- `load`=1 in any state: go to IDLE, `cnt`<=0, and no event is accepted that cycle. `load` has priority over a simultaneous event. `rco_d` still updates.
- `clr_flags`=1 clears `mismatch` and `overflow`. A set condition in the same cycle wins over `clr_flags`.
- `wrap_count` wraps silently from 2^WRAP_W-1 to 0.
- `period` holds its value between events. It is not cleared by `load`.

## Timing
- Reset (synchronous, edge with `reset`=1):
  - state IDLE
  - `cnt`, `rco_d`, `period`, `period_valid`, `q_snap`, `wrap_count`, `mismatch`, `overflow`, `busy` all 0.
  - Reset overrides every other input, including mid-RUN. Because `rco_d` resets to 0, an `rco` held high through reset release counts as an event on the first edge after release.
- Latency: `period`, `period_valid`, `q_snap`, `wrap_count` and `mismatch` update at the same edge that samples the event, so they are visible one cycle after `rco` rises.
- `period_valid` is high for exactly one cycle per accepted RUN event.
- Period arithmetic: for events sampled at edges t and t+k, `period`=k, for 1<=k<2^PERIOD_W-1. Larger gaps report 2^PERIOD_W-1 and set `overflow`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `reset` for 3 cycles with `rco` toggling -> all outputs 0, `busy`=0. Release with `rco`=1 -> next edge gives `wrap_count`=1, `busy`=1, `period_valid`=0.
- Steady wrap: counter in count-up mode, `enable`=1, `exp_period`=16 -> `period_valid` pulses every 16 cycles with `period`=16, `q_snap`=0, `mismatch`=0. After 5 events `wrap_count`=5.
- Mismatch: same stimulus with `exp_period`=15 -> `mismatch`=1 after the second event and stays 1. Pulse `clr_flags` -> 0. Set `exp_period`=0 -> `mismatch` stays 0.
- Load abort: assert `load` for 1 cycle 7 cycles after an event -> `busy`=0. The next event reports no period. The event after that reports `period`=distance between those two events. Load and rco rising on the same edge -> `wrap_count` unchanged, state IDLE.
- Saturation: PERIOD_W=8, `enable`=0 for 300 cycles in RUN -> `overflow`=1. The next event reports `period`=255 and `mismatch`=1 when `exp_period`=16.
- Wrap counter: WRAP_W=8, 257 events -> `wrap_count`=1. Reset asserted mid-RUN -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/counter_rco_monitor.sv
// counter_rco_monitor
// Watches the 4-bit counter's rco/load/Q outputs. It counts accepted rco
// rising edges and measures the cycle distance between consecutive edges.
// Each measured period is checked against a programmed expected value.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   rco          ripple-carry-out from the counter
//   load         load indicator from the counter (aborts a measurement)
//   Q            counter value, captured into q_snap on accepted events
//   exp_period   expected cycles between rco rising edges (0 = no check)
//   clr_flags    clears the sticky mismatch/overflow flags
//   period       last measured period (held between events)
//   period_valid one-cycle pulse when period updates
//   q_snap       Q sampled at the last accepted event
//   wrap_count   accepted events, modulo 2^WRAP_W
//   mismatch     sticky: measured period differed from nonzero exp_period
//   overflow     sticky: period counter saturated
//   busy         high while measuring (RUN state)
module counter_rco_monitor #(
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rco,
  input  logic                load,
  input  logic [3:0]          Q,
  input  logic [PERIOD_W-1:0] exp_period,
  input  logic                clr_flags,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [3:0]          q_snap,
  output logic [WRAP_W-1:0]   wrap_count,
  output logic                mismatch,
  output logic                overflow,
  output logic                busy
);

  localparam int unsigned Q_W = 4;
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_nxt;
  logic                rco_d;
  logic [PERIOD_W-1:0] period_nxt;
  logic                period_valid_nxt;
  logic [Q_W-1:0]      q_snap_nxt;
  logic [WRAP_W-1:0]   wrap_count_nxt;
  logic                mismatch_nxt;
  logic                overflow_nxt;
  logic                busy_nxt;
  logic                mismatch_set_c;
  logic                overflow_set_c;
  logic                rco_evt_c;

  // Rising edge of rco; a multi-cycle-high rco yields a single event.
  assign rco_evt_c = rco & ~rco_d;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rco_d        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      q_snap       <= '0;
      wrap_count   <= '0;
      mismatch     <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rco_d        <= rco;
      period       <= period_nxt;
      period_valid <= period_valid_nxt;
      q_snap       <= q_snap_nxt;
      wrap_count   <= wrap_count_nxt;
      mismatch     <= mismatch_nxt;
      overflow     <= overflow_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    period_nxt       = period;
    period_valid_nxt = 1'b0;
    q_snap_nxt       = q_snap;
    wrap_count_nxt   = wrap_count;
    mismatch_set_c   = 1'b0;
    overflow_set_c   = 1'b0;

    if (load) begin
      // load aborts any measurement and masks a coincident event.
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rco_evt_c) begin
            // First edge only starts the measurement; no period yet.
            state_nxt      = RUN;
            cnt_nxt        = PERIOD_W'(1);
            wrap_count_nxt = wrap_count + WRAP_W'(1);
            q_snap_nxt     = Q;
          end
        end
        RUN: begin
          if (rco_evt_c) begin
            period_nxt       = cnt;
            period_valid_nxt = 1'b1;
            wrap_count_nxt   = wrap_count + WRAP_W'(1);
            q_snap_nxt       = Q;
            cnt_nxt          = PERIOD_W'(1);
            mismatch_set_c   = (exp_period != '0) && (cnt != exp_period);
          end else begin
            // Saturating count; reaching the ceiling flags overflow.
            if (cnt != CNT_MAX) begin
              cnt_nxt = cnt + PERIOD_W'(1);
            end
            overflow_set_c = (cnt_nxt == CNT_MAX);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // A set condition in the same cycle wins over clr_flags.
    mismatch_nxt = mismatch_set_c | (mismatch & ~clr_flags);
    overflow_nxt = overflow_set_c | (overflow & ~clr_flags);
    busy_nxt     = (state_nxt == RUN);
  end

endmodule
